serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 98 +++++++++
 tb/tb_serial_adder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: LSB-first, one full-adder slice plus a carry flop, 3-state FSM.
// Optional SERIAL_ADDER_OVF_EN adds a two's-complement overflow output (ovf).
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;

    logic sum_bit;
    logic carry_next;
    logic last_bit;

    assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry_reg;
    assign carry_next = (a_reg[0] & b_reg[0]) | (carry_reg & (a_reg[0] ^ b_reg[0]));
    assign last_bit   = (cnt_reg == CW'(WIDTH - 1));

    assign busy = (state_reg == SHIFT);
    assign done = (state_reg == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
            sum       <= '0;
            cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        a_reg     <= a;
                        b_reg     <= b;
                        carry_reg <= cin;
                        cnt_reg   <= '0;
                        sum       <= '0;
                        cout      <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf       <= 1'b0;
`endif
                        state_reg <= SHIFT;
                    end
                end
                SHIFT: begin
                    sum       <= {sum_bit, sum[WIDTH-1:1]};
                    a_reg     <= a_reg >> 1;
                    b_reg     <= b_reg >> 1;
                    carry_reg <= carry_next;
                    cnt_reg   <= cnt_reg + 1'b1;
                    if (last_bit) begin
                        cout      <= carry_next;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_reg is the carry into the MSB slice on the last bit
                        ovf       <= carry_reg ^ carry_next;
`endif
                        state_reg <= DONE;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder (WIDTH=8): stimulus pushes expectations, a monitor pops on done.
// Also exercises ovf when SERIAL_ADDER_OVF_EN is defined.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic         ovf;
`endif

    serial_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         c;
        logic         o;
        int           cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   busy_cnt = 0;
    int   last_done = 0;
    bit   have_last = 0;
    bit   burst = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: pops one expectation per done pulse.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            busy_cnt = 0;
        end else begin
            if (busy) busy_cnt++;
            if (done) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1, expected no done (t=%0t)", $time);
                end else begin
                    e = q.pop_front();
                    chk("sum", 32'(sum), 32'(e.s));
                    chk("cout", 32'(cout), 32'(e.c));
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", 32'(ovf), 32'(e.o));
`endif
                    chk("latency", cyc - e.cyc, W);
                    chk("busy_cycles", busy_cnt, W);
                    $display("op done: sum=%02h cout=%0d latency=%0d busy=%0d", sum, cout, cyc - e.cyc, busy_cnt);
                end
                if (burst && have_last) chk("done_spacing", cyc - last_done, W + 2);
                last_done = cyc;
                have_last = 1;
                busy_cnt  = 0;
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results, expected 0", q.size());
            q.delete();
        end
    endtask

    // One directed addition; poke>0 pulses a bogus start that many cycles into SHIFT.
    task automatic do_add(logic [W-1:0] av, logic [W-1:0] bv, logic ci,
                          logic [W-1:0] es, logic ec, logic eo, int poke);
        exp_t e;
        @(negedge clk);
        a = av; b = bv; cin = ci; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.s = es; e.c = ec; e.o = eo; e.cyc = cyc;
        q.push_back(e);
        a = 8'h3C; b = 8'hC3; cin = ~ci;
        if (poke > 0) begin
            repeat (poke) @(negedge clk);
            a = 8'h03; b = 8'h00; cin = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        drain();
        repeat (3) @(negedge clk);
        chk("hold_sum", 32'(sum), 32'(es));
        chk("hold_cout", 32'(cout), 32'(ec));
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        logic [W:0] full;
        exp_t e;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        #3;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", 32'(ovf), 0);
`endif
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        do_add(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0, 0);
        do_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, 0);
        do_add(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 0);
        do_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 3);

        // Abort mid-SHIFT with an asynchronous reset.
        @(negedge clk);
        a = 8'hF0; b = 8'h0F; cin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_sum", 32'(sum), 0);
        chk("abort_done", 32'(done), 0);
        chk("abort_cout", 32'(cout), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_abort_done", 32'(done), 0);
        do_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, 0);

        // Back-to-back with start held high.
        burst = 1; have_last = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
            start = 1'b1;
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
            @(posedge clk);
            #1;
            e.s = full[W-1:0];
            e.c = full[W];
            e.o = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
            e.cyc = cyc;
            q.push_back(e);
            if (i == 199) start = 1'b0;
            repeat (9) @(posedge clk);
        end
        drain();
        burst = 0;
        repeat (12) @(negedge clk);
        chk("final_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
